// File: rtl/mem_loader.sv
// mem_loader -- boot-time program loader in front of the instruction memory.
//
// Takes a framed byte stream and writes the payload into memory at one byte
// per cycle. The CPU core is held in reset until the whole image has landed.
// Stream frame, little-endian:
//   addr_lo, addr_hi, len_lo, len_hi, payload[len], [checksum]
//
// Optional feature: define MEM_LOADER_CHECKSUM_EN to expect one trailing
// checksum byte. The checksum is the sum of the payload mod 2^DATA_WIDTH.
// A mismatch parks the loader in ERROR until load_req or reset.
//
// Ports:
//   clk, reset           rising-edge clock, synchronous active-high reset
//   in_valid/in_data     stream byte; a byte transfers on in_valid && in_ready
//   in_ready             high while loading (header, data, checksum states)
//   load_req             pulse; restarts loading from DONE or ERROR only
//   mem_we/addr/din      registered memory write port, one write per payload byte
//   cpu_reset_n          active-low core reset; rises one cycle after DONE is entered
//   busy / done / error  status flags

module mem_loader #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  in_ready,
    input  logic                  load_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_din,
    output logic                  cpu_reset_n,
    output logic                  busy,
    output logic                  done,
    output logic                  error
);

    // Length header is two stream bytes wide.
    localparam int LEN_WIDTH = 2 * DATA_WIDTH;

    typedef enum logic [2:0] {
        ST_ADDR_LO = 3'd0,
        ST_ADDR_HI = 3'd1,
        ST_LEN_LO  = 3'd2,
        ST_LEN_HI  = 3'd3,
        ST_DATA    = 3'd4,
`ifdef MEM_LOADER_CHECKSUM_EN
        ST_CSUM    = 3'd5,
        ST_ERROR   = 3'd7,
`endif
        ST_DONE    = 3'd6
    } state_t;

    // Registered memory write port.
    typedef struct packed {
        logic                  we;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] din;
    } mem_wr_t;

    // State reached once the payload (or an empty header) is finished.
`ifdef MEM_LOADER_CHECKSUM_EN
    localparam state_t ST_PAYLOAD_END = ST_CSUM;
`else
    localparam state_t ST_PAYLOAD_END = ST_DONE;
`endif

    state_t                  state_q, state_d;
    logic [DATA_WIDTH-1:0]   hdr_lo_q;     // low byte of the header word being captured
    logic [ADDR_WIDTH-1:0]   addr_q;       // next payload write address
    logic [LEN_WIDTH-1:0]    remain_q;     // payload bytes still to come
    mem_wr_t                 wr_q;
    logic                    cpu_rst_n_q;
`ifdef MEM_LOADER_CHECKSUM_EN
    logic [DATA_WIDTH-1:0]   csum_q;
`endif

    logic                    accept;
    logic                    idle;
    logic                    restart;
    logic [LEN_WIDTH-1:0]    hdr_word;

    // DONE and ERROR are the only states that refuse bytes.
`ifdef MEM_LOADER_CHECKSUM_EN
    assign idle = (state_q == ST_DONE) || (state_q == ST_ERROR);
`else
    assign idle = (state_q == ST_DONE);
`endif

    assign busy     = !idle;
    assign in_ready = !idle;
    assign accept   = in_valid && in_ready;
    assign restart  = idle && load_req;
    // The high header byte is combined with the stored low byte as it arrives.
    assign hdr_word = {in_data, hdr_lo_q};

    // ---------------- FSM state register ----------------
    always_ff @(posedge clk) begin
        if (reset) state_q <= ST_ADDR_LO;
        else       state_q <= state_d;
    end

    // ---------------- FSM next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_ADDR_LO: if (accept) state_d = ST_ADDR_HI;
            ST_ADDR_HI: if (accept) state_d = ST_LEN_LO;
            ST_LEN_LO:  if (accept) state_d = ST_LEN_HI;
            ST_LEN_HI:  if (accept) state_d = (hdr_word != '0) ? ST_DATA : ST_PAYLOAD_END;
            ST_DATA:    if (accept && remain_q == LEN_WIDTH'(1)) state_d = ST_PAYLOAD_END;
`ifdef MEM_LOADER_CHECKSUM_EN
            ST_CSUM:    if (accept) state_d = (in_data == csum_q) ? ST_DONE : ST_ERROR;
            ST_ERROR:   if (load_req) state_d = ST_ADDR_LO;
`endif
            ST_DONE:    if (load_req) state_d = ST_ADDR_LO;
            default:    state_d = ST_ADDR_LO;
        endcase
    end

    // ---------------- datapath ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            hdr_lo_q    <= '0;
            addr_q      <= '0;
            remain_q    <= '0;
            wr_q        <= '0;
            cpu_rst_n_q <= 1'b0;
`ifdef MEM_LOADER_CHECKSUM_EN
            csum_q      <= '0;
`endif
        end else begin
            wr_q.we <= 1'b0;
            // Registered off DONE, so the core leaves reset only after the
            // final write (issued in the first DONE cycle) has been captured.
            cpu_rst_n_q <= (state_q == ST_DONE) && !load_req;

            if (restart) begin
                hdr_lo_q <= '0;
                addr_q   <= '0;
                remain_q <= '0;
`ifdef MEM_LOADER_CHECKSUM_EN
                csum_q   <= '0;
`endif
            end else if (accept) begin
                case (state_q)
                    ST_ADDR_LO, ST_LEN_LO: hdr_lo_q <= in_data;
                    // Truncation drops header bits above ADDR_WIDTH.
                    ST_ADDR_HI: addr_q   <= ADDR_WIDTH'(hdr_word);
                    ST_LEN_HI:  remain_q <= hdr_word;
                    ST_DATA: begin
                        wr_q.we   <= 1'b1;
                        wr_q.addr <= addr_q;
                        wr_q.din  <= in_data;
                        addr_q    <= addr_q + ADDR_WIDTH'(1);   // wraps naturally
                        remain_q  <= remain_q - LEN_WIDTH'(1);
`ifdef MEM_LOADER_CHECKSUM_EN
                        csum_q    <= csum_q + in_data;
`endif
                    end
                    default: ;
                endcase
            end
        end
    end

    assign mem_we      = wr_q.we;
    assign mem_addr    = wr_q.addr;
    assign mem_din     = wr_q.din;
    assign cpu_reset_n = cpu_rst_n_q;
    assign done        = (state_q == ST_DONE);
`ifdef MEM_LOADER_CHECKSUM_EN
    assign error       = (state_q == ST_ERROR);
`else
    assign error       = 1'b0;
`endif

endmodule

// File: tb/tb_mem_loader.sv
`timescale 1ns/1ps
module tb_mem_loader;
    localparam int AW = 16;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          load_req = 1'b0;
    logic          in_ready, mem_we, cpu_reset_n, busy, done, error;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_din;

    mem_loader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .load_req(load_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_din(mem_din), .cpu_reset_n(cpu_reset_n),
        .busy(busy), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    // Edge counter: between edge k and edge k+1 it reads k.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // Observed writes with the cycle they were presented in.
    logic [AW-1:0] wq_addr[$];
    logic [DW-1:0] wq_data[$];
    int            wq_cyc[$];
    // Edge number at which each stream byte was accepted.
    int            acc_q[$];

    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            wq_addr.push_back(mem_addr);
            wq_data.push_back(mem_din);
            wq_cyc.push_back(cyc);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, " mem_we"},      mem_we, 0);
        chk({tag, " mem_addr"},    mem_addr, 0);
        chk({tag, " mem_din"},     mem_din, 0);
        chk({tag, " cpu_reset_n"}, cpu_reset_n, 0);
        chk({tag, " busy"},        busy, 1);
        chk({tag, " done"},        done, 0);
        chk({tag, " error"},       error, 0);
        chk({tag, " in_ready"},    in_ready, 1);
    endtask

    task automatic idle_cycle();
        in_valid = 1'b0;
        in_data  = DW'($urandom);
        step();
    endtask

    // mode 0: back to back, 1: bubble every other cycle,
    // 2: random bubbles plus stray load_req pulses that must be ignored.
    // Called and returns at #1 after a rising edge.
    task automatic send_stream(input logic [7:0] s[$], input int mode);
        acc_q = {};
        for (int i = 0; i < s.size(); i++) begin
            if (mode == 1 && i > 0) idle_cycle();
            else if (mode == 2) begin
                for (int k = 0; k < 3 && $urandom_range(0, 1) == 1; k++) idle_cycle();
            end
            in_valid = 1'b1;
            in_data  = s[i];
            load_req = (mode == 2) && ($urandom_range(0, 3) == 0);
            @(negedge clk);
            chk($sformatf("in_ready byte%0d", i), in_ready, 1);
            step();
            acc_q.push_back(cyc);
            in_valid = 1'b0;
            load_req = 1'b0;
        end
    endtask

    // Streams one image and checks completion timing plus the full write list
    // against the framing rules: write i goes to (a+i) mod 2^16 with d[i],
    // presented in the cycle right after its byte was accepted.
    task automatic run_load(input string tag, input logic [15:0] a, input int len,
                            input logic [15:0][7:0] d, input int mode);
        logic [7:0]  s[$];
        logic [15:0] ln;
        logic [7:0]  sum;
        logic [15:0] ea;
        int          last_we;
        ln  = 16'(len);
        sum = '0;
        s   = {};
        s.push_back(a[7:0]);  s.push_back(a[15:8]);
        s.push_back(ln[7:0]); s.push_back(ln[15:8]);
        for (int i = 0; i < len; i++) begin
            s.push_back(d[i]);
            sum = sum + d[i];
        end
`ifdef MEM_LOADER_CHECKSUM_EN
        s.push_back(sum);
        last_we = 0;
`else
        last_we = (len > 0) ? 1 : 0;
`endif
        wq_addr = {}; wq_data = {}; wq_cyc = {};
        send_stream(s, mode);
        // cycle N+1 after the final byte
        @(negedge clk);
        chk({tag, " done@N+1"},        done, 1);
        chk({tag, " busy@N+1"},        busy, 0);
        chk({tag, " cpu_reset_n@N+1"}, cpu_reset_n, 0);
        chk({tag, " mem_we@N+1"},      mem_we, 32'(last_we));
        @(negedge clk);
        chk({tag, " cpu_reset_n@N+2"}, cpu_reset_n, 1);
        chk({tag, " mem_we@N+2"},      mem_we, 0);
        chk({tag, " in_ready@N+2"},    in_ready, 0);
        chk({tag, " error@N+2"},       error, 0);
        step(); step();
        chk({tag, " nwrites"}, wq_addr.size(), 32'(len));
        for (int i = 0; i < len && i < wq_addr.size(); i++) begin
            ea = a + 16'(i);
            chk($sformatf("%s wr%0d addr", tag, i), wq_addr[i], ea);
            chk($sformatf("%s wr%0d data", tag, i), wq_data[i], d[i]);
            chk($sformatf("%s wr%0d cycle", tag, i), wq_cyc[i], acc_q[4 + i]);
        end
    endtask

    // From DONE/ERROR: pulse load_req, confirm the restart, realign.
    task automatic restart(input string tag);
        step();
        load_req = 1'b1;
        step();
        load_req = 1'b0;
        @(negedge clk);
        chk({tag, " restart cpu_reset_n"}, cpu_reset_n, 0);
        chk({tag, " restart busy"},        busy, 1);
        chk({tag, " restart done"},        done, 0);
        chk({tag, " restart in_ready"},    in_ready, 1);
        step();
    endtask

    typedef struct {
        logic [15:0]      addr;
        int               len;
        logic [15:0][7:0] d;
        int               mode;
        int               exp_n;
        logic [15:0]      exp_first;
        logic [15:0]      exp_last;
    } vec_t;

    vec_t vecs[4];

    initial begin
        logic [7:0]       s[$];
        logic [15:0][7:0] rd;
        logic [15:0]      ra;
        int               rl, rm;

        // table: basic, bubbles, wrap, zero length
        vecs[0].addr = 16'h0200; vecs[0].len = 4; vecs[0].d = '0;
        vecs[0].d[0] = 8'hA9; vecs[0].d[1] = 8'h04; vecs[0].d[2] = 8'h85; vecs[0].d[3] = 8'h02;
        vecs[0].mode = 0; vecs[0].exp_n = 4; vecs[0].exp_first = 16'h0200; vecs[0].exp_last = 16'h0203;
        vecs[1] = vecs[0];
        vecs[1].mode = 1;
        vecs[2].addr = 16'hFFFE; vecs[2].len = 3; vecs[2].d = '0;
        vecs[2].d[0] = 8'h11; vecs[2].d[1] = 8'h22; vecs[2].d[2] = 8'h33;
        vecs[2].mode = 0; vecs[2].exp_n = 3; vecs[2].exp_first = 16'hFFFE; vecs[2].exp_last = 16'h0000;
        vecs[3].addr = 16'h1000; vecs[3].len = 0; vecs[3].d = '0;
        vecs[3].mode = 0; vecs[3].exp_n = 0; vecs[3].exp_first = 16'h0000; vecs[3].exp_last = 16'h0000;

        step(); step();
        @(negedge clk);
        chk_reset_vals("reset");
        reset = 1'b0;
        step();

        for (int v = 0; v < 4; v++) begin
            run_load($sformatf("vec%0d", v), vecs[v].addr, vecs[v].len, vecs[v].d, vecs[v].mode);
            chk($sformatf("vec%0d exp_n", v), wq_addr.size(), 32'(vecs[v].exp_n));
            if (wq_addr.size() > 0) begin
                chk($sformatf("vec%0d first", v), wq_addr[0], vecs[v].exp_first);
                chk($sformatf("vec%0d last", v), wq_addr[wq_addr.size() - 1], vecs[v].exp_last);
            end
            restart($sformatf("vec%0d", v));
        end

        // reset after two of four payload bytes
        wq_addr = {}; wq_data = {}; wq_cyc = {};
        s = {8'h00, 8'h30, 8'h04, 8'h00, 8'hAA, 8'hBB};
        send_stream(s, 0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        @(negedge clk);
        chk_reset_vals("midreset");
        chk("midreset nwrites", wq_addr.size(), 2);
        step();
        rd = '0; rd[0] = 8'h5A; rd[1] = 8'hC3; rd[2] = 8'h0F;
        run_load("reload", 16'h4000, 3, rd, 0);
        restart("reload");

`ifdef MEM_LOADER_CHECKSUM_EN
        // bad checksum parks in ERROR
        s = {8'h00, 8'h50, 8'h02, 8'h00, 8'h01, 8'h02, 8'h04};
        send_stream(s, 0);
        @(negedge clk);
        chk("csum error",       error, 1);
        chk("csum cpu_reset_n", cpu_reset_n, 0);
        chk("csum in_ready",    in_ready, 0);
        chk("csum done",        done, 0);
        step(); step(); step();
        @(negedge clk);
        chk("csum error hold",       error, 1);
        chk("csum cpu_reset_n hold", cpu_reset_n, 0);
        restart("csum");
        rd = '0; rd[0] = 8'h01; rd[1] = 8'h02;
        run_load("csum ok", 16'h5000, 2, rd, 0);
        restart("csum ok");
`endif

        // randomized images, biased toward the top of memory to exercise wrap
        for (int r = 0; r < 8; r++) begin
            ra = ($urandom_range(0, 1) == 1) ? 16'(16'hFFF0 + $urandom_range(0, 15)) : 16'($urandom);
            rl = $urandom_range(0, 16);
            rm = $urandom_range(0, 2);
            for (int i = 0; i < 16; i++) rd[i] = 8'($urandom);
            run_load($sformatf("rand%0d", r), ra, rl, rd, rm);
            restart($sformatf("rand%0d", r));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
